// File: rtl/param_seq_det.sv
// Runtime-programmable Mealy serial sequence detector: 1..MAX_LEN bit pattern,
// overlapping or non-overlapping matching, input-valid qualifier, saturating match counter.
module param_seq_det #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = 'b1001,
    parameter int                 DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               enabled;
    logic               fill_ok;
    logic               match;
    logic [MAX_LEN-1:0] w;
    logic [MAX_LEN-1:0] mask;

    always_comb begin
        accept  = in_valid & ~cfg_load;
        w       = {hist_q, in};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        enabled = (len_q != '0) && (int'(len_q) <= MAX_LEN);
        fill_ok = (int'(fill_q) + 1) >= int'(len_q);
        // Pattern bits at or above len are masked off on both sides.
        match   = accept & enabled & fill_ok & ((w & mask) == (pat_q & mask));
        out     = match;

        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = w[MAX_LEN-2:0];
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVL;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign match_count = cnt_q;

endmodule

// File: doc/param_seq_det.md
# param_seq_det

Runtime-programmable Mealy serial sequence detector. It generalises the fixed "1001" overlapping detector to any pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching, an input-valid qualifier and a saturating match counter. It sits on a single-bit serial stream in the same datapath position as the fixed detector. Reset configuration reproduces the legacy behaviour: pattern 1001, length 4, overlapping.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of length fields.
- CNT_W, 8: match counter width.
- DEF_PAT, 'b1001: reset pattern (LSB-aligned).
- DEF_LEN, 4: reset pattern length.
- DEF_OVL, 1: reset mode (1 = overlapping).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies `in`; bit is consumed only when high.
- cfg_load  in  1  one-cycle pulse that loads the cfg_* fields.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cnt_clr  in  1  clears match_count.
- out  out  1  Mealy match flag, combinational in the cycle the final bit is presented.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- Active config registers: pat, len, ovl.
  - Reset values: DEF_PAT, DEF_LEN, DEF_OVL.
  - Loaded from cfg_* on cfg_load.
- History register hist has MAX_LEN-1 bits. The newest accepted bit is at bit 0. On an accepted bit: hist <= {hist[MAX_LEN-3:0], in}.
- Fill counter fill counts accepted bits since the last clear and saturates at MAX_LEN.
- Window w = {hist, in}.
- match = in_valid & ~cfg_load & enabled & (fill ≥ len-1) & (w[len-1:0] == pat[len-1:0]).
  - enabled = (1 ≤ len ≤ MAX_LEN).
  - Bits of pat at or above len are ignored.
- out = match.
- Accepted bit (in_valid & ~cfg_load):
  - hist always shifts.
  - On a match with ovl=0, fill <= 0.
  - Otherwise fill <= min(fill+1, MAX_LEN).
- in_valid low: hist and fill hold, out=0.
- cfg_load:
  - Loads pat, len, ovl.
  - Clears hist and fill.
  - Has priority over in_valid in the same cycle; that input bit is discarded and out=0.
- Illegal len (0 or >MAX_LEN): the block is disabled and out stays 0. hist and fill still update.
- match_count:
  - Increments on match and saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment: a match in the same cycle as cnt_clr is not counted and the count becomes 0.
- reset:
  - hist=0, fill=0, match_count=0, and config returns to the DEF_* values.
  - Reset mid-stream discards partial progress; the next match needs len fresh bits.

## Timing
- out is combinational from in, in_valid and state, with zero latency: it asserts in the same cycle as the last pattern bit.
- hist, fill and config update on the next posedge.
- match_count reflects a match one cycle after out asserts.
- During reset, out=0 because fill=0 and len ≥ 2 (requires DEF_LEN ≥ 2). match_count reads 0 the cycle after reset is sampled.
- New config takes effect on the first accepted bit after the cfg_load cycle.
- No handshake back-pressure: every valid bit is consumed.

## Test plan
- **Reset defaults, overlapping:** after reset, stream 1,0,0,1,0,0,1 with in_valid=1 -> out=1 on bits 4 and 7 only; match_count=2.
- **Non-overlapping, 1001:** cfg_load pattern 1001, len 4, ovl=0; stream 1,0,0,1,0,0,1,1,0,0,1 -> out on bits 4 and 11 only; count=2.
- **Pattern 11, both modes:** len 2, stream 1,1,1,1. With ovl=1 -> out on bits 2,3,4. With ovl=0 -> out on bits 2,4.
- **Valid gaps:** default config; bits 1,0 valid; 3 idle cycles with in=1; then bits 0,1 valid -> single out on the final bit; no out during idle cycles.
- **Reset and cfg_load mid-sequence:** send 1,0,0, then assert reset one cycle, then send 1 -> no match. Send 1,0,0, then cfg_load with in_valid=1 and in=1 -> no match; the bit is discarded.
- **Counter saturation and clear:** CNT_W=2, 5 matches -> count=3. cnt_clr coincident with a match -> count=0. Illegal len=0 -> out never asserts.
